// File: rtl/main_bist.sv
// -----------------------------------------------------------------------------
// main_bist -- top level of the sync-detector test chip.
//
// Wraps a K/J symbol sync-detector core with an on-chip logic BIST made of an
// LFSR pattern generator, a MISR response compactor and a small controller.
// In normal operation the core is fed from the pins; a BIST run substitutes
// LFSR patterns for the pins and finishes with a signature pass/fail verdict.
//
// Build option:
//   MAIN_BIST_EN  defined   -> LFSR, MISR and BIST controller are present.
//                 undefined -> core always driven from the pins, bist_start is
//                              ignored, pass_fail and bist_end are tied low.
//
// Parameters:
//   BIST_CYCLES  pattern cycles applied per BIST run
//   SEED         LFSR load value at BIST start
//   GOLDEN       expected fault-free MISR signature
//
// Ports:
//   CLK             single rising-edge clock
//   RST             asynchronous active-low reset
//   bist_start      BIST request, rising edge detected synchronously
//   in_k, in_j      K and J lines of the incoming symbol
//   in_en           symbol valid strobe
//   out_synced_d    sync-locked flag, registered once more after the core
//   out_sync_err_d  invalid-symbol pulse, registered once more after the core
//   pass_fail       1 = signature matched GOLDEN, valid while bist_end = 1
//   bist_end        BIST complete flag
// -----------------------------------------------------------------------------
module main_bist #(
    parameter int          BIST_CYCLES = 512,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter logic [15:0] GOLDEN      = 16'h0000
) (
    input  logic CLK,
    input  logic RST,
    input  logic bist_start,
    input  logic in_k,
    input  logic in_j,
    input  logic in_en,
    output logic out_synced_d,
    output logic out_sync_err_d,
    output logic pass_fail,
    output logic bist_end
);

    // Sync pattern K J K J K J K K: Pn means the first n symbols have matched.
    typedef enum logic [3:0] {
        P0, P1, P2, P3, P4, P5, P6, P7, LOCK
    } sync_state_t;

    sync_state_t sync_state;
    logic        sync_err;
    logic        synced;

    // Core stimulus after the pin/LFSR selection, plus the BIST-entry clear.
    logic core_k;
    logic core_j;
    logic core_en;
    logic core_clr;

    assign synced = (sync_state == LOCK);

    // -------------------------------------------------------------------------
    // Sync-detector core (the circuit under test)
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_state     <= P0;
            sync_err       <= 1'b0;
            out_synced_d   <= 1'b0;
            out_sync_err_d <= 1'b0;
        end else if (core_clr) begin
            sync_state     <= P0;
            sync_err       <= 1'b0;
            out_synced_d   <= 1'b0;
            out_sync_err_d <= 1'b0;
        end else begin
            out_synced_d   <= synced;
            out_sync_err_d <= sync_err;
            if (!core_en) begin
                // No symbol this cycle: the FSM holds, the error pulse ends.
                sync_err <= 1'b0;
            end else if (core_k == core_j) begin
                sync_state <= P0;
                sync_err   <= 1'b1;
            end else begin
                sync_err <= 1'b0;
                // Valid symbol, so core_k alone tells K (1) from J (0).
                unique case (sync_state)
                    P0:      sync_state <= core_k ? P1   : P0;
                    P1:      sync_state <= core_k ? P1   : P2;
                    P2:      sync_state <= core_k ? P3   : P0;
                    P3:      sync_state <= core_k ? P1   : P4;
                    P4:      sync_state <= core_k ? P5   : P0;
                    P5:      sync_state <= core_k ? P1   : P6;
                    P6:      sync_state <= core_k ? P7   : P0;
                    // K J K J K J K + J still ends in K J K J K J, i.e. P6.
                    P7:      sync_state <= core_k ? LOCK : P6;
                    LOCK:    sync_state <= LOCK;
                    default: sync_state <= P0;
                endcase
            end
        end
    end

`ifdef MAIN_BIST_EN

    // -------------------------------------------------------------------------
    // BIST: LFSR pattern generator, MISR compactor, controller
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE, RUN, DONE
    } bist_state_t;

    localparam int               CNT_W    = (BIST_CYCLES > 1) ? $clog2(BIST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIST_CYCLES - 1);

    bist_state_t      bist_state;
    logic             start_q;
    logic             start_rise;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_next;
    logic [15:0]      misr;
    logic [15:0]      misr_next;
    logic [CNT_W-1:0] cycle_cnt;
    logic             running;
    logic             entering_run;

    // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting towards the MSB.
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign misr_next = {misr[14:0], misr[15] ^ misr[13] ^ misr[12] ^ misr[10]}
                     ^ {14'b0, out_synced_d, out_sync_err_d};

    assign running      = (bist_state == RUN);
    assign entering_run = start_rise && !running;

    assign core_k   = running ? lfsr[0]             : in_k;
    assign core_j   = running ? lfsr[1]             : in_j;
    assign core_en  = running ? (lfsr[2] | lfsr[3]) : in_en;
    assign core_clr = entering_run;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bist_state <= IDLE;
            start_q    <= 1'b0;
            start_rise <= 1'b0;
            lfsr       <= SEED;
            misr       <= 16'h0000;
            cycle_cnt  <= '0;
            pass_fail  <= 1'b0;
            bist_end   <= 1'b0;
        end else begin
            start_q    <= bist_start;
            // Edges seen while a run is in progress are dropped, and because
            // start_q follows the pin a held request never retriggers.
            start_rise <= bist_start && !start_q && !running;

            unique case (bist_state)
                IDLE, DONE: begin
                    if (start_rise) begin
                        bist_state <= RUN;
                        lfsr       <= SEED;
                        misr       <= 16'h0000;
                        cycle_cnt  <= '0;
                        pass_fail  <= 1'b0;
                        bist_end   <= 1'b0;
                    end
                end
                RUN: begin
                    lfsr      <= lfsr_next;
                    misr      <= misr_next;
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (cycle_cnt == CNT_LAST) begin
                        bist_state <= DONE;
                        bist_end   <= 1'b1;
                        // Judge the signature including this final response.
                        pass_fail  <= (misr_next == GOLDEN);
                    end
                end
                default: bist_state <= IDLE;
            endcase
        end
    end

`else

    // BIST absent: the pins always own the core and the verdict is inert.
    assign core_k    = in_k;
    assign core_j    = in_j;
    assign core_en   = in_en;
    assign core_clr  = 1'b0;
    assign pass_fail = 1'b0;
    assign bist_end  = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{SEED, GOLDEN, bist_start} ^ (BIST_CYCLES != 0);

`endif

endmodule

// File: tb/tb_main_bist.sv
// -----------------------------------------------------------------------------
// tb_main_bist -- self-checking bench for main_bist.
//
// Core behaviour is checked through a scoreboard: each driven symbol pushes
// the expected {out_synced_d, out_sync_err_d} pair, which is popped and
// compared one edge later (the registered outputs lag the core by one cycle).
// With MAIN_BIST_EN defined, a second instance carries a GOLDEN with bit 0
// flipped so both verdicts are exercised; the fault-free signature is computed
// by a bench-side model at elaboration.
// -----------------------------------------------------------------------------
module tb_main_bist;

    localparam int          BIST_CYCLES = 512;
    localparam logic [15:0] SEED        = 16'hACE1;
    localparam logic [3:0]  LOCK_ST     = 4'd8;

    // Next core state for one symbol; bit n of pat is 1 when Pn expects K.
    function automatic logic [3:0] sync_next(input logic [3:0] st, input logic k,
                                             input logic j, input logic en);
        logic [7:0] pat;
        logic [3:0] nxt;
        pat = 8'hD5;
        if (!en)                   nxt = st;
        else if (k == j)           nxt = 4'd0;
        else if (st == LOCK_ST)    nxt = LOCK_ST;
        else if (k == pat[st[2:0]]) nxt = st + 4'd1;
        else if (st == 4'd7)       nxt = 4'd6;
        else if (!pat[st[2:0]])    nxt = 4'd1;
        else                       nxt = 4'd0;
        return nxt;
    endfunction

`ifdef MAIN_BIST_EN
    // Cycle-accurate model of one BIST run, returning the final signature.
    function automatic logic [15:0] calc_sig(input int n, input logic [15:0] seed);
        logic [15:0] lf;
        logic [15:0] mi;
        logic [3:0]  st;
        logic        er, syd, erd, k, j, en;
        lf = seed; mi = 16'h0000; st = 4'd0; er = 1'b0; syd = 1'b0; erd = 1'b0;
        for (int b = 0; b < 32; b++) begin
            for (int c = 0; c < 32; c++) begin
                if (b * 32 + c < n) begin
                    k  = lf[0];
                    j  = lf[1];
                    en = lf[2] | lf[3];
                    mi = {mi[14:0], mi[15] ^ mi[13] ^ mi[12] ^ mi[10]} ^ {14'b0, syd, erd};
                    syd = (st == LOCK_ST);
                    erd = er;
                    er  = en && (k == j);
                    st  = sync_next(st, k, j, en);
                    lf  = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
                end
            end
        end
        return mi;
    endfunction
    localparam logic [15:0] MODEL_SIG = calc_sig(BIST_CYCLES, SEED);
`else
    localparam logic [15:0] MODEL_SIG = 16'h0000;
`endif

    logic CLK;
    logic RST;
    logic bist_start;
    logic in_k;
    logic in_j;
    logic in_en;
    logic out_synced_d,  out_sync_err_d,  pass_fail,  bist_end;
    logic bad_synced_d,  bad_sync_err_d,  bad_pass,   bad_end;

    main_bist #(.BIST_CYCLES(BIST_CYCLES), .SEED(SEED), .GOLDEN(MODEL_SIG)) dut (
        .CLK(CLK), .RST(RST), .bist_start(bist_start),
        .in_k(in_k), .in_j(in_j), .in_en(in_en),
        .out_synced_d(out_synced_d), .out_sync_err_d(out_sync_err_d),
        .pass_fail(pass_fail), .bist_end(bist_end)
    );

    main_bist #(.BIST_CYCLES(BIST_CYCLES), .SEED(SEED), .GOLDEN(MODEL_SIG ^ 16'h0001)) dut_bad (
        .CLK(CLK), .RST(RST), .bist_start(bist_start),
        .in_k(in_k), .in_j(in_j), .in_en(in_en),
        .out_synced_d(bad_synced_d), .out_sync_err_d(bad_sync_err_d),
        .pass_fail(bad_pass), .bist_end(bad_end)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int         tests = 0;
    int         fails = 0;
    logic [3:0] model_st;
    logic [1:0] sb[$];

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Restart the scoreboard from the reset/cleared state of the core.
    task automatic sb_reset();
        model_st = 4'd0;
        sb.delete();
        sb.push_back(2'b00);
    endtask

    // Drive one symbol for one cycle and compare the outputs due after it.
    task automatic step(input logic k, input logic j, input logic en);
        logic [3:0] nxt;
        logic [1:0] exp;
        in_k  = k;
        in_j  = j;
        in_en = en;
        nxt   = sync_next(model_st, k, j, en);
        sb.push_back({nxt == LOCK_ST, en && (k == j)});
        model_st = nxt;
        @(posedge CLK);
        #1;
        exp = sb.pop_front();
        check("synced_d", {15'b0, out_synced_d}, {15'b0, exp[1]});
        check("sync_err_d", {15'b0, out_sync_err_d}, {15'b0, exp[0]});
    endtask

    // Send valid symbols MSB first, 1 = K and 0 = J.
    task automatic send_seq(input logic [15:0] syms, input int len);
        for (int i = len - 1; i >= 0; i--) begin
            step(syms[i], !syms[i], 1'b1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

`ifdef MAIN_BIST_EN
    // One BIST run: hold the request for 10 cycles, measure edge-to-end.
    task automatic run_bist(input string tag);
        int cnt;
        bist_start = 1'b1;
        @(posedge CLK);   // edge on which the request is sampled
        #1;
        cnt = 0;
        for (int i = 1; i <= BIST_CYCLES + 20; i++) begin
            @(posedge CLK);
            #1;
            if (i == 10) bist_start = 1'b0;
            if (i == 1) check({tag, "_end_low_at_entry"}, {15'b0, bist_end}, 16'h0);
            if (bist_end) begin
                cnt = i;
                break;
            end
        end
        if (cnt == 0) cnt = BIST_CYCLES + 21;
        check({tag, "_latency"}, cnt[15:0], 16'(BIST_CYCLES + 1));
        check({tag, "_pass"}, {15'b0, pass_fail}, 16'h1);
        check({tag, "_bad_end"}, {15'b0, bad_end}, 16'h1);
        check({tag, "_bad_fail"}, {15'b0, bad_pass}, 16'h0);
        repeat (3) @(posedge CLK);
        #1;
        check({tag, "_pass_held"}, {15'b0, pass_fail}, 16'h1);
        check({tag, "_end_held"}, {15'b0, bist_end}, 16'h1);
    endtask
`endif

    initial begin
        logic seen_end;
        RST = 1'b0; bist_start = 1'b0; in_k = 1'b0; in_j = 1'b0; in_en = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_synced_d", {15'b0, out_synced_d}, 16'h0);
        check("rst_sync_err_d", {15'b0, out_sync_err_d}, 16'h0);
        check("rst_pass_fail", {15'b0, pass_fail}, 16'h0);
        check("rst_bist_end", {15'b0, bist_end}, 16'h0);
        RST = 1'b1;

        sb_reset();
        idle(4);
        check("idle_bist_end", {15'b0, bist_end}, 16'h0);

        // Lock, stay locked on further symbols.
        send_seq(16'h00AB, 8);
        send_seq(16'h0005, 4);
        // Invalid symbol while locked, then quiet cycles.
        step(1'b1, 1'b1, 1'b1);
        idle(3);
        // Overlap path through P7 + J.
        send_seq(16'h02AB, 10);
        idle(2);
        // k = j = 0 is also invalid; en low holds state mid-pattern.
        step(1'b0, 1'b0, 1'b1);
        send_seq(16'h000A, 4);
        idle(3);
        send_seq(16'h000B, 4);
        // Assorted traffic, including mismatches from every state.
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0));
            if (i % 50 == 0) send_seq(16'h00AB, 8);
        end
        idle(2);

`ifdef MAIN_BIST_EN
        run_bist("bist1");
        run_bist("bist2");
`else
        bist_start = 1'b1;
        seen_end = 1'b0;
        for (int i = 0; i < BIST_CYCLES + 20; i++) begin
            @(posedge CLK);
            #1;
            if (i == 10) bist_start = 1'b0;
            if (bist_end || pass_fail) seen_end = 1'b1;
        end
        check("nobist_end_tied", {15'b0, seen_end}, 16'h0);
`endif

        // Reset in the middle of a run.
        bist_start = 1'b1;
        repeat (100) @(posedge CLK);
        #1;
        bist_start = 1'b0;
        RST = 1'b0;
        #2;
        check("abort_synced_d", {15'b0, out_synced_d}, 16'h0);
        check("abort_sync_err_d", {15'b0, out_sync_err_d}, 16'h0);
        check("abort_pass_fail", {15'b0, pass_fail}, 16'h0);
        check("abort_bist_end", {15'b0, bist_end}, 16'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        seen_end = 1'b0;
        for (int i = 0; i < BIST_CYCLES + 20; i++) begin
            @(posedge CLK);
            #1;
            if (bist_end) seen_end = 1'b1;
        end
        check("abort_no_end", {15'b0, seen_end}, 16'h0);

        // The pins own the core again after the aborted run.
        sb_reset();
        send_seq(16'h00AB, 8);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/main_bist.md
# main_bist

Top-level of the sync-detector test chip. It wraps a K/J symbol sync-detector core (the circuit under test) with an on-chip logic BIST. The BIST consists of an LFSR pattern generator, a MISR response compactor and a controller. In normal mode the core is driven from the primary inputs. When a BIST run is requested, the core is driven by the LFSR, and the run ends with a pass/fail verdict.

## Interface
- BIST_CYCLES, 512: number of pattern cycles applied per BIST run.
- SEED, 16'hACE1: LFSR load value at BIST start.
- GOLDEN, 16'h0000: expected MISR signature. Set at integration to the fault-free signature of this spec.
- CLK  input  1  single clock; everything is rising-edge triggered.
- RST  input  1  reset, asynchronous, active-low.
- bist_start  input  1  BIST request; its rising edge is detected synchronously.
- in_k  input  1  K line of the incoming symbol.
- in_j  input  1  J line of the incoming symbol.
- in_en  input  1  symbol valid strobe.
- out_synced_d  output  1  registered sync-locked flag.
- out_sync_err_d  output  1  registered invalid-symbol pulse.
- pass_fail  output  1  1 = signature matched GOLDEN; valid while bist_end=1.
- bist_end  output  1  BIST complete flag.

## Operation
- Symbol decode is applied only when en=1; when en=0 the core holds all state.
  - K: k=1, j=0.
  - J: k=0, j=1.
  - Invalid: k==j.
- Core FSM states are P0..P7, plus LOCK. The sync pattern is K J K J K J K K.
- Matching transitions:
  - Pn advances to Pn+1 on the expected symbol.
  - P7 + K goes to LOCK.
- Mismatch transitions:
  - A state expecting J (P1/P3/P5) that receives K goes to P1.
  - P0/P2/P4/P6 receiving J go to P0.
  - P7 receiving J goes to P6.
- LOCK holds on any valid symbol. Internal synced=1 in LOCK only.
- An invalid symbol in any state forces P0, and internal sync_err=1 for that cycle.
- out_synced_d and out_sync_err_d are the internal signals registered one cycle later.
- BIST controller states are IDLE, RUN and DONE.
  - IDLE to RUN on a bist_start rising edge. On entry: LFSR=SEED, MISR=0, cycle counter=0, core FSM and output registers synchronously cleared.
  - RUN applies core inputs from the LFSR instead of the pins: k=lfsr[0], j=lfsr[1], en=lfsr[2]|lfsr[3].
  - LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shifts every RUN cycle.
  - MISR: same polynomial. Each RUN cycle, {out_synced_d, out_sync_err_d} is XORed into bits [1:0] on the shift.
  - RUN to DONE after BIST_CYCLES cycles. pass_fail is registered as (MISR==GOLDEN).
  - DONE: bist_end=1, pass_fail held. DONE returns to RUN on a new bist_start rising edge, with the same re-initialisation as IDLE to RUN.
- bist_start edges during RUN are ignored. Holding bist_start high does not retrigger.
- Outside RUN, the core is driven by in_k, in_j and in_en.

## Timing
- Reset values: all outputs 0, core in P0, controller IDLE, LFSR=SEED, MISR=0.
- Reset asserted mid-RUN aborts the run immediately, back to IDLE with reset values.
- Symbol to internal output takes 1 cycle; to the _d ports it takes 2 cycles.
- bist_start edge latency:
  - Edge sampled at clock n: RUN from n+1.
  - First LFSR pattern applied in cycle n+1.
  - bist_end rises at n+1+BIST_CYCLES.
- pass_fail and bist_end change on the same edge.

## Configuration
- MAIN_BIST_EN defined:
  - Full BIST logic is present as above.
- MAIN_BIST_EN undefined:
  - No LFSR, MISR or controller.
  - Core is always driven from the pins.
  - bist_start is ignored.
  - pass_fail and bist_end are tied 0.

## Test plan
- RST low, then high; drive no symbols:
  - all outputs 0.
  - bist_end stays 0.
- en=1, feed K J K J K J K K:
  - out_synced_d rises 2 cycles after the final K.
  - out_synced_d stays 1 on further K/J.
- While locked, drive k=j=1 with en=1:
  - out_sync_err_d is a 1-cycle pulse.
  - out_synced_d drops.
  - FSM restarts at P0.
- Feed K J K J K J K J K K:
  - overlap handling (P7+J→P6) leads to lock after the final K.
- Hold bist_start=1 for 10 cycles, with GOLDEN equal to the signature from the bench model:
  - bist_end=1 exactly BIST_CYCLES+1 cycles after the edge.
  - pass_fail=1.
- Repeat with GOLDEN bit 0 flipped:
  - pass_fail=0.
- Separately, assert RST mid-RUN:
  - outputs return to 0.
  - no bist_end.
